// File: rtl/pipe_stage_buf_pkg.sv
// Shared widths, occupancy encodings and buffer state type for the generic
// pipeline-stage register.
package pipe_stage_buf_pkg;

    localparam int WORD_LEN          = 32;
    localparam int REG_FILE_ADDR_LEN = 5;
    // {WB_EN, MEM_R_EN, dest, ALURes, memReadVal}
    localparam int MEMWB_W           = 2 + REG_FILE_ADDR_LEN + 2 * WORD_LEN;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    function automatic logic [1:0] occ_of(input buf_state_t s);
        case (s)
            ST_ONE:  return OCC_ONE;
            ST_TWO:  return OCC_TWO;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for per-stage stall statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline-stage register with flush, optional two-entry skid
// buffer, occupancy reporting and a saturating stall counter.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int DATA_W = MEMWB_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    buf_state_t        state, state_nxt;
    logic [DATA_W-1:0] main_q, main_nxt;
    logic [DATA_W-1:0] skid_q, skid_nxt;
    logic              in_fire, out_fire;

    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = main_q;
    assign occupancy = occ_of(state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_EMPTY;
            main_q <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
        end
    end

    // Main register is zeroed whenever it empties so bubbles carry an all-zero payload.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = ST_EMPTY;
            main_nxt  = '0;
            skid_nxt  = '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ST_ONE;
                        main_nxt  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_nxt = in_data;
                    end else if (in_fire && (SKID != 0)) begin
                        state_nxt = ST_TWO;
                        skid_nxt  = in_data;
                    end else if (out_fire) begin
                        state_nxt = ST_EMPTY;
                        main_nxt  = '0;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_nxt = ST_ONE;
                        main_nxt  = skid_q;
                        skid_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                    main_nxt  = '0;
                    skid_nxt  = '0;
                end
            endcase
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            // in_ready is "skid slot free" as seen after this edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_q     <= '0;
                    in_ready_q <= 1'b1;
                end else begin
                    skid_q     <= skid_nxt;
                    in_ready_q <= (state_nxt != ST_TWO);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            logic unused_skid;

            assign unused_skid = ^skid_nxt;
            assign skid_q      = '0;
            assign in_ready    = !out_valid || out_ready;
        end
    endgenerate

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_ready),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: queue-based reference model, directed scenarios
// and randomized traffic on skid, no-skid and narrow-counter instances.
module tb_pipe_stage_buf;

    localparam int DW = 71;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance A (SKID=1, CNT_W=16) and C (SKID=1, CNT_W=2) share stimulus
    logic          flush_a, in_valid_a, out_ready_a;
    logic [DW-1:0] in_data_a;
    logic          in_ready_a, out_valid_a;
    logic [DW-1:0] out_data_a;
    logic [1:0]    occupancy_a;
    logic [15:0]   stall_cnt_a;
    logic          in_ready_c, out_valid_c;
    logic [DW-1:0] out_data_c;
    logic [1:0]    occupancy_c;
    logic [1:0]    stall_cnt_c;
    // instance B (SKID=0)
    logic          flush_b, in_valid_b, out_ready_b;
    logic [DW-1:0] in_data_b;
    logic          in_ready_b, out_valid_b;
    logic [DW-1:0] out_data_b;
    logic [1:0]    occupancy_b;
    logic [15:0]   stall_cnt_b;

    pipe_stage_buf #(.DATA_W(DW), .SKID(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(out_data_a), .occupancy(occupancy_a), .stall_cnt(stall_cnt_a));

    pipe_stage_buf #(.DATA_W(DW), .SKID(1), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_c),
        .in_data(in_data_a), .out_valid(out_valid_c), .out_ready(out_ready_a),
        .out_data(out_data_c), .occupancy(occupancy_c), .stall_cnt(stall_cnt_c));

    pipe_stage_buf #(.DATA_W(DW), .SKID(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .occupancy(occupancy_b), .stall_cnt(stall_cnt_b));

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: FIFO contents and stall counts
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    int  stall_a, stall_b;
    bit  fired_a, fired_b;

    function automatic logic [90:0] exp_a();
        logic [DW-1:0] h;
        logic ir, ov;
        h  = (qa.size() > 0) ? qa[0] : '0;
        ir = (qa.size() < 2);
        ov = (qa.size() > 0);
        return {ir, ov, 2'(qa.size()), h, 16'(stall_a)};
    endfunction

    function automatic logic [76:0] exp_c();
        logic [DW-1:0] h;
        logic ir, ov;
        h  = (qa.size() > 0) ? qa[0] : '0;
        ir = (qa.size() < 2);
        ov = (qa.size() > 0);
        return {ir, ov, 2'(qa.size()), h, 2'((stall_a > 3) ? 3 : stall_a)};
    endfunction

    function automatic logic [90:0] exp_b();
        logic [DW-1:0] h;
        logic ir, ov;
        h  = (qb.size() > 0) ? qb[0] : '0;
        ir = (qb.size() == 0) || out_ready_b;
        ov = (qb.size() > 0);
        return {ir, ov, 2'(qb.size()), h, 16'(stall_b)};
    endfunction

    task automatic step_a();
        logic ir, ov;
        ir = (qa.size() < 2);
        ov = (qa.size() > 0);
        fired_a = in_valid_a && ir;
        if (ov && !out_ready_a && stall_a < 65535) stall_a++;
        if (flush_a) qa.delete();
        else begin
            if (ov && out_ready_a) void'(qa.pop_front());
            if (fired_a) qa.push_back(in_data_a);
        end
    endtask

    task automatic step_b();
        logic ir, ov;
        ir = (qb.size() == 0) || out_ready_b;
        ov = (qb.size() > 0);
        fired_b = in_valid_b && ir;
        if (ov && !out_ready_b && stall_b < 65535) stall_b++;
        if (flush_b) qb.delete();
        else begin
            if (ov && out_ready_b) void'(qb.pop_front());
            if (fired_b) qb.push_back(in_data_b);
        end
    endtask

    // advance model and DUTs by one edge; inputs are re-driven 1 time unit after it
    task automatic adv();
        step_a();
        step_b();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        flush_a = 0; in_valid_a = 0; out_ready_a = 0; in_data_a = '0;
        flush_b = 0; in_valid_b = 0; out_ready_b = 0; in_data_b = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete(); qb.delete();
        stall_a = 0; stall_b = 0;
    endtask

    task automatic test_reset();
        logic [90:0] got;
        flush_a = 0; in_valid_a = 0; out_ready_a = 0; in_data_a = '0;
        flush_b = 0; in_valid_b = 0; out_ready_b = 0; in_data_b = '0;
        rst = 1'b1;
        #1;
        got = {in_ready_a, out_valid_a, occupancy_a, out_data_a, stall_cnt_a};
        n_tests++;
        if (got !== {1'b1, 90'd0}) begin
            n_fail++; $display("FAIL reset_a got=%h exp=%h", got, {1'b1, 90'd0});
        end
        got = {in_ready_b, out_valid_b, occupancy_b, out_data_b, stall_cnt_b};
        n_tests++;
        if (got !== {1'b1, 90'd0}) begin
            n_fail++; $display("FAIL reset_b got=%h exp=%h", got, {1'b1, 90'd0});
        end
        n_tests++;
        if ({in_ready_c, out_valid_c, occupancy_c, out_data_c, stall_cnt_c} !== {1'b1, 76'd0}) begin
            n_fail++; $display("FAIL reset_c got=%h", {in_ready_c, out_valid_c, occupancy_c, out_data_c, stall_cnt_c});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete(); qb.delete();
        stall_a = 0; stall_b = 0;
    endtask

    task automatic test_stream();
        logic [DW-1:0] vals[3];
        logic [90:0]   got;
        vals = '{71'h11, 71'h22, 71'h33};
        do_reset();
        out_ready_a = 1;
        for (int i = 0; i < 5; i++) begin
            in_valid_a = (i < 3);
            in_data_a  = (i < 3) ? vals[i] : '0;
            @(negedge clk);
            got = {in_ready_a, out_valid_a, occupancy_a, out_data_a, stall_cnt_a};
            n_tests++;
            if (got !== exp_a()) begin
                n_fail++; $display("FAIL stream_model cyc=%0d got=%h exp=%h", i, got, exp_a());
            end
            if (i >= 1 && i <= 3) begin
                n_tests++;
                if (out_data_a !== vals[i-1] || out_valid_a !== 1'b1) begin
                    n_fail++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", i, out_data_a, vals[i-1]);
                end
            end
            adv();
        end
        n_tests++;
        if (stall_cnt_a !== 16'd0) begin
            n_fail++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt_a);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] want[3];
        logic [DW-1:0] got[$];
        int k;
        want = '{71'hA, 71'hB, 71'hC};
        do_reset();
        out_ready_a = 0;
        k = 0;
        in_valid_a = 1;
        in_data_a  = want[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            adv();
            if (fired_a) begin
                k++;
                if (k < 3) in_data_a = want[k];
                else in_valid_a = 0;
            end
        end
        @(negedge clk);
        n_tests++;
        if (occupancy_a !== 2'd2 || in_ready_a !== 1'b0 || out_data_a !== want[0]) begin
            n_fail++; $display("FAIL bp_full occ=%0d in_ready=%0b data=%h exp occ=2 in_ready=0 data=%h",
                               occupancy_a, in_ready_a, out_data_a, want[0]);
        end
        n_tests++;
        if (stall_cnt_a !== 16'd4) begin
            n_fail++; $display("FAIL bp_stall got=%0d exp=4", stall_cnt_a);
        end
        out_ready_a = 1;
        #1;
        for (int i = 0; i < 10 && got.size() < 3; i++) begin
            if (i > 0) @(negedge clk);
            if (out_valid_a && out_ready_a) got.push_back(out_data_a);
            adv();
            if (fired_a) in_valid_a = 0;
        end
        n_tests++;
        if (got.size() != 3) begin
            n_fail++; $display("FAIL bp_timeout got %0d entries exp 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (got[i] !== want[i]) begin
                    n_fail++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], want[i]);
                end
            end
        end
        n_tests++;
        if (stall_cnt_a !== 16'd4) begin
            n_fail++; $display("FAIL bp_stall_final got=%0d exp=4", stall_cnt_a);
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready_a = 0;
        in_valid_a = 1; in_data_a = 71'h1;
        @(negedge clk); adv();
        in_data_a = 71'h2;
        @(negedge clk); adv();
        flush_a = 1; in_valid_a = 1; in_data_a = 71'h5;
        @(negedge clk);
        n_tests++;
        if (occupancy_a !== 2'd2) begin
            n_fail++; $display("FAIL flush_pre occ=%0d exp=2", occupancy_a);
        end
        adv();
        flush_a = 0; in_valid_a = 0; out_ready_a = 1;
        @(negedge clk);
        n_tests++;
        if ({out_valid_a, occupancy_a, out_data_a, in_ready_a} !== {3'b000, 71'd0, 1'b1}) begin
            n_fail++; $display("FAIL flush_post valid=%0b occ=%0d data=%h in_ready=%0b exp 0/0/0/1",
                               out_valid_a, occupancy_a, out_data_a, in_ready_a);
        end
        n_tests++;
        if (stall_cnt_a !== 16'd2) begin
            n_fail++; $display("FAIL flush_keeps_stall got=%0d exp=2", stall_cnt_a);
        end
        for (int i = 0; i < 4; i++) begin
            adv();
            @(negedge clk);
            n_tests++;
            if (out_valid_a !== 1'b0) begin
                n_fail++; $display("FAIL flush_leak cyc=%0d valid=%0b data=%h exp valid=0", i, out_valid_a, out_data_a);
            end
        end
        flush_a = 1; in_valid_a = 1; in_data_a = 71'h6;
        adv();
        flush_a = 0; in_valid_a = 0;
        @(negedge clk);
        n_tests++;
        if (occupancy_a !== 2'd0 || out_valid_a !== 1'b0) begin
            n_fail++; $display("FAIL flush_same_cycle occ=%0d valid=%0b exp 0/0", occupancy_a, out_valid_a);
        end
        adv();
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready_a = 0;
        in_valid_a = 1; in_data_a = 71'h9;
        @(negedge clk); adv();
        in_valid_a = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); adv();
        end
        @(negedge clk);
        n_tests++;
        if (stall_cnt_c !== 2'd3) begin
            n_fail++; $display("FAIL sat_narrow got=%0d exp=3", stall_cnt_c);
        end
        n_tests++;
        if (stall_cnt_a !== 16'd6 || stall_cnt_a !== 16'(stall_a)) begin
            n_fail++; $display("FAIL sat_wide got=%0d exp=6", stall_cnt_a);
        end
        adv();
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready_a = 0;
        in_valid_a = 1; in_data_a = 71'h1;
        @(negedge clk); adv();
        in_data_a = 71'h2;
        @(negedge clk); adv();
        in_valid_a = 0;
        @(negedge clk);
        n_tests++;
        if (occupancy_a !== 2'd2) begin
            n_fail++; $display("FAIL arst_pre occ=%0d exp=2", occupancy_a);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({in_ready_a, out_valid_a, occupancy_a, out_data_a, stall_cnt_a} !== {1'b1, 90'd0}) begin
            n_fail++; $display("FAIL arst_a in_ready=%0b valid=%0b occ=%0d data=%h stall=%0d exp 1/0/0/0/0",
                               in_ready_a, out_valid_a, occupancy_a, out_data_a, stall_cnt_a);
        end
        n_tests++;
        if ({in_ready_c, out_valid_c, occupancy_c, stall_cnt_c} !== 6'b100000) begin
            n_fail++; $display("FAIL arst_c got=%b exp=100000", {in_ready_c, out_valid_c, occupancy_c, stall_cnt_c});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete(); qb.delete();
        stall_a = 0; stall_b = 0;
        in_valid_a = 1; in_data_a = 71'h44; out_ready_a = 1;
        @(negedge clk); adv();
        in_valid_a = 0;
        @(negedge clk);
        n_tests++;
        if (out_valid_a !== 1'b1 || out_data_a !== 71'h44) begin
            n_fail++; $display("FAIL arst_first_accept valid=%0b data=%h exp 1/44", out_valid_a, out_data_a);
        end
        adv();
    endtask

    task automatic test_noskid();
        do_reset();
        in_valid_b = 1; in_data_b = 71'h3; out_ready_b = 0;
        @(negedge clk);
        n_tests++;
        if (in_ready_b !== 1'b1) begin
            n_fail++; $display("FAIL ns_empty_ready got=%0b exp=1", in_ready_b);
        end
        adv();
        in_valid_b = 0;
        @(negedge clk);
        n_tests++;
        if (in_ready_b !== 1'b0 || out_data_b !== 71'h3) begin
            n_fail++; $display("FAIL ns_stall_ready in_ready=%0b data=%h exp 0/3", in_ready_b, out_data_b);
        end
        out_ready_b = 1; in_valid_b = 1; in_data_b = 71'h7;
        #1;
        n_tests++;
        if (in_ready_b !== 1'b1) begin
            n_fail++; $display("FAIL ns_comb_ready got=%0b exp=1", in_ready_b);
        end
        adv();
        in_valid_b = 0; out_ready_b = 0;
        @(negedge clk);
        n_tests++;
        if (out_data_b !== 71'h7 || occupancy_b !== 2'd1 || out_valid_b !== 1'b1) begin
            n_fail++; $display("FAIL ns_replace data=%h occ=%0d valid=%0b exp 7/1/1", out_data_b, occupancy_b, out_valid_b);
        end
        adv();
    endtask

    task automatic test_random();
        logic [95:0] r;
        logic [90:0] ga, gb;
        logic [76:0] gc;
        bit pend_a, pend_b;
        do_reset();
        pend_a = 0; pend_b = 0;
        for (int i = 0; i < 400; i++) begin
            out_ready_a = ($urandom_range(0, 3) != 0);
            out_ready_b = ($urandom_range(0, 3) != 0);
            flush_a     = ($urandom_range(0, 24) == 0);
            flush_b     = ($urandom_range(0, 24) == 0);
            if (!pend_a) begin
                r = {$urandom, $urandom, $urandom};
                in_valid_a = $urandom_range(0, 1) != 0;
                in_data_a  = r[DW-1:0];
            end
            if (!pend_b) begin
                r = {$urandom, $urandom, $urandom};
                in_valid_b = $urandom_range(0, 1) != 0;
                in_data_b  = r[DW-1:0];
            end
            @(negedge clk);
            ga = {in_ready_a, out_valid_a, occupancy_a, out_data_a, stall_cnt_a};
            gc = {in_ready_c, out_valid_c, occupancy_c, out_data_c, stall_cnt_c};
            gb = {in_ready_b, out_valid_b, occupancy_b, out_data_b, stall_cnt_b};
            n_tests++;
            if (ga !== exp_a()) begin
                n_fail++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", i, ga, exp_a());
            end
            n_tests++;
            if (gc !== exp_c()) begin
                n_fail++; $display("FAIL rand_c cyc=%0d got=%h exp=%h", i, gc, exp_c());
            end
            n_tests++;
            if (gb !== exp_b()) begin
                n_fail++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", i, gb, exp_b());
            end
            adv();
            pend_a = in_valid_a && !fired_a;
            pend_b = in_valid_b && !fired_b;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturation();
        test_async_reset();
        test_noskid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
